// File: rtl/pipe_add_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
package pipe_add_tree_pkg;

  localparam int MIN_OPS   = 2;
  localparam int MAX_OPS   = 16;
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of elements entering tree level k (level 0 is the raw operand list).
  function automatic int ops_at_level(input int n, input int k);
    int m;
    m = n;
    for (int i = 0; i < k; i++) m = (m + 1) / 2;
    return m;
  endfunction

  function automatic logic ext_bit(input logic msb, input logic sgn);
    return sgn ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/pipe_add_tree_stage.sv
// One registered level of the adder tree: pairwise sums, odd passthrough,
// valid bit with en-based load/hold and synchronous flush.
module pipe_add_tree_stage
  import pipe_add_tree_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int IW     = 10,
  parameter int SIGNED = 0,
  localparam int N_OUT = (N_IN + 1) / 2,
  localparam int OW    = IW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [N_IN*IW-1:0]    in_data,
  input  logic                  in_valid,
  output logic [N_OUT*OW-1:0]   out_data,
  output logic                  out_valid
);

  logic [2*N_OUT*IW-1:0] padded;
  logic [N_OUT*OW-1:0]   sum;

  function automatic logic [OW-1:0] ext(input logic [IW-1:0] x);
    return {ext_bit(x[IW-1], SIGNED != 0), x};
  endfunction

  // A zero pad on an odd count turns the leftover element into a plain extension.
  always_comb begin
    padded = '0;
    padded[N_IN*IW-1:0] = in_data;
    sum = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum[j*OW +: OW] = ext(padded[2*j*IW +: IW]) + ext(padded[(2*j+1)*IW +: IW]);
    end
  end

  // Data only loads on a real transfer so a held word is never disturbed by bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= sum;
    end
  end

endmodule

// File: rtl/pipe_add_tree.sv
// Parametrised pipelined multi-operand adder with valid/ready flow control,
// bubble collapsing, signed mode and synchronous flush.
module pipe_add_tree
  import pipe_add_tree_pkg::*;
#(
  parameter int NUM_OPS = 3,
  parameter int WIDTH   = 10,
  parameter int SIGNED  = 0,
  localparam int LEVELS = clog2(NUM_OPS),
  localparam int OWIDTH = WIDTH + LEVELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  if (NUM_OPS < MIN_OPS || NUM_OPS > MAX_OPS || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH ||
      SIGNED < 0 || SIGNED > 1) begin : g_bad_params
    $error("pipe_add_tree: parameter out of legal range");
  end

  logic [LEVELS:0]   en;
  logic [LEVELS-1:0] v;

  // Ready chain: a stage may load when it is empty or its successor is loading.
  always_comb begin
    en = '0;
    en[LEVELS] = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      en[k] = ~v[k] | en[k+1];
    end
  end

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int NI = ops_at_level(NUM_OPS, i);
    localparam int IW = WIDTH + i;
    localparam int NO = (NI + 1) / 2;

    logic [NI*IW-1:0]     din;
    logic [NO*(IW+1)-1:0] dout;
    logic                 vin;

    if (i == 0) begin : g_first
      assign din = in_data;
      assign vin = in_valid;
    end else begin : g_next
      assign din = g_lvl[i-1].dout;
      assign vin = v[i-1];
    end

    pipe_add_tree_stage #(
      .N_IN   (NI),
      .IW     (IW),
      .SIGNED (SIGNED)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (en[i]),
      .in_data   (din),
      .in_valid  (vin),
      .out_data  (dout),
      .out_valid (v[i])
    );
  end

  assign in_ready  = en[0];
  assign out_valid = v[LEVELS-1];
  assign out_data  = g_lvl[LEVELS-1].dout;

endmodule

// File: tb/tb_pipe_add_tree.sv
// Scoreboard bench for pipe_add_tree: default, signed and 5x8 instances.
module tb_pipe_add_tree;

  logic clk = 1'b0;
  logic rst, clr, ordy;
  logic [29:0] in0, in1;
  logic [39:0] in2;
  logic iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2;
  logic [11:0] od0, od1;
  logic [10:0] od2;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [10:0] q2[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_add_tree #(.NUM_OPS(3), .WIDTH(10), .SIGNED(0)) u_def (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in0), .in_valid(iv0), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(ordy));

  pipe_add_tree #(.NUM_OPS(3), .WIDTH(10), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy));

  pipe_add_tree #(.NUM_OPS(5), .WIDTH(8), .SIGNED(0)) u_five (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(ordy));

  function automatic logic [11:0] sum3u(input logic [29:0] d);
    return {2'b00, d[9:0]} + {2'b00, d[19:10]} + {2'b00, d[29:20]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; ordy = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    in0 = '0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_ov0 got %b want 0", ov0); end
    checks++; if (od0 !== 12'h000) begin errors++; $display("FAIL reset_od0 got %h want 000", od0); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b want 0", ov1); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b want 0", ov2); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_ir0 got %b want 1", ir0); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int got = 0;
    ordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin in0 = {10'd1023, 10'd1023, 10'd1023}; iv0 = 1'b1; end
      else iv0 = 1'b0;
      #1;
      if (c == 1) begin
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL single_early got ov=%b want 0", ov0); end
      end
      if (ov0 && ordy) begin
        checks++;
        if (q0.size() == 0 || od0 !== q0[0] || c != 2) begin
          errors++; $display("FAIL single_out got %h at cycle %0d want bfd at cycle 2", od0, c);
        end
        if (q0.size() != 0) void'(q0.pop_front());
        got++;
      end
      if (iv0 && ir0) q0.push_back(12'hBFD);
    end
    checks++; if (got != 1) begin errors++; $display("FAIL single_count got %0d want 1", got); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] vecs[3];
    int sent = 0;
    int got = 0;
    vecs[0] = {10'd3, 10'd2, 10'd1};
    vecs[1] = {10'd6, 10'd5, 10'd4};
    vecs[2] = {10'd9, 10'd8, 10'd7};
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sent < 3) begin in0 = vecs[sent]; iv0 = 1'b1; end
      else iv0 = 1'b0;
      #1;
      if (ov0 && ordy) begin
        checks++;
        if (q0.size() == 0 || od0 !== q0[0] || c != got + 2) begin
          errors++; $display("FAIL b2b_out got %0d at cycle %0d want word %0d at cycle %0d", od0, c, got, got + 2);
        end
        if (q0.size() != 0) void'(q0.pop_front());
        got++;
      end
      if (iv0 && ir0) begin
        q0.push_back(sent == 0 ? 12'd6 : (sent == 1 ? 12'd15 : 12'd24));
        sent++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int got = 0;
    int maxq = 0;
    logic [11:0] held = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ordy = !(c >= 2 && c < 7);
      if (sent < 8) begin
        in0 = {10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0))};
        iv0 = 1'b1;
      end else iv0 = 1'b0;
      #1;
      if (c == 3) held = od0;
      if (c == 6) begin
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", ir0); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", ov0); end
        checks++; if (od0 !== held) begin errors++; $display("FAIL stall_hold got %h want %h", od0, held); end
      end
      if (ov0 && ordy) begin
        checks++;
        if (q0.size() == 0 || od0 !== q0[0]) begin
          errors++; $display("FAIL stall_out got %h want %h", od0, (q0.size() == 0) ? 12'h000 : q0[0]);
        end
        if (q0.size() != 0) void'(q0.pop_front());
        got++;
      end
      if (iv0 && ir0) begin q0.push_back(sum3u(in0)); sent++; end
      if (q0.size() > maxq) maxq = q0.size();
    end
    iv0 = 1'b0;
    checks++; if (maxq > 2) begin errors++; $display("FAIL stall_inflight got %0d want <=2", maxq); end
    checks++; if (got != 8) begin errors++; $display("FAIL stall_count got %0d want 8", got); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL stall_left got %0d want 0", q0.size()); end
  endtask

  task automatic test_signed();
    logic [29:0] vecs[2];
    logic [11:0] exps[2];
    int sent = 0;
    int got = 0;
    vecs[0] = {10'h200, 10'h200, 10'h200};
    exps[0] = 12'hA00;
    vecs[1] = {10'd0, 10'd1, 10'h3FF};
    exps[1] = 12'h000;
    ordy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sent < 2) begin in1 = vecs[sent]; iv1 = 1'b1; end
      else iv1 = 1'b0;
      #1;
      if (ov1 && ordy) begin
        checks++;
        if (q1.size() == 0 || od1 !== q1[0]) begin
          errors++; $display("FAIL signed_out got %h want %h", od1, (q1.size() == 0) ? 12'h000 : q1[0]);
        end
        if (q1.size() != 0) void'(q1.pop_front());
        got++;
      end
      if (iv1 && ir1) begin q1.push_back(exps[sent]); sent++; end
    end
    checks++; if (got != 2) begin errors++; $display("FAIL signed_count got %0d want 2", got); end
  endtask

  task automatic test_five();
    logic [39:0] vecs[2];
    logic [10:0] exps[2];
    int sent = 0;
    int got = 0;
    vecs[0] = {5{8'd255}};
    exps[0] = 11'h4FB;
    vecs[1] = {8'd128, 8'd4, 8'd3, 8'd2, 8'd1};
    exps[1] = 11'd138;
    ordy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (sent < 2) begin in2 = vecs[sent]; iv2 = 1'b1; end
      else iv2 = 1'b0;
      #1;
      if (ov2 && ordy) begin
        checks++;
        if (q2.size() == 0 || od2 !== q2[0] || c != got + 3) begin
          errors++; $display("FAIL five_out got %h at cycle %0d want word %0d at cycle %0d", od2, c, got, got + 3);
        end
        if (q2.size() != 0) void'(q2.pop_front());
        got++;
      end
      if (iv2 && ir2) begin q2.push_back(exps[sent]); sent++; end
    end
    checks++; if (got != 2) begin errors++; $display("FAIL five_count got %0d want 2", got); end
  endtask

  task automatic test_rst_midflight();
    ordy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in0 = {10'd100, 10'd200, 10'(300 + c)};
      iv0 = 1'b1;
      #1;
      if (iv0 && ir0) q0.push_back(sum3u(in0));
    end
    @(negedge clk);
    iv0 = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b1 || q0.size() != 2 || od0 !== q0[0]) begin
      errors++; $display("FAIL rst_pre got ov=%b data=%h inflight=%0d want ov=1 data=258 inflight=2", ov0, od0, q0.size());
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_async_ov got %b want 0", ov0); end
    checks++; if (od0 !== 12'h000) begin errors++; $display("FAIL rst_async_od got %h want 000", od0); end
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ir0); end
  endtask

  task automatic test_clr();
    logic [11:0] held;
    int got = 0;
    ordy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in0 = {10'd11, 10'd22, 10'(33 + c)};
      iv0 = 1'b1;
      #1;
      if (iv0 && ir0) q0.push_back(sum3u(in0));
    end
    @(negedge clk);
    clr = 1'b1;
    in0 = {10'd500, 10'd500, 10'd500};
    iv0 = 1'b1;
    #1;
    held = od0;
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", ir0); end
    q0.delete();
    @(negedge clk);
    clr = 1'b0;
    iv0 = 1'b0;
    ordy = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", ov0); end
    checks++; if (od0 !== held) begin errors++; $display("FAIL clr_data got %h want %h", od0, held); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL clr_ready_after got %b want 1", ir0); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin in0 = {10'd7, 10'd70, 10'd700}; iv0 = 1'b1; end
      else iv0 = 1'b0;
      #1;
      if (ov0 && ordy) begin
        checks++;
        if (q0.size() == 0 || od0 !== q0[0] || c != 2) begin
          errors++; $display("FAIL clr_next_out got %h at cycle %0d want 309 at cycle 2", od0, c);
        end
        if (q0.size() != 0) void'(q0.pop_front());
        got++;
      end
      if (iv0 && ir0) q0.push_back(12'h309);
    end
    checks++; if (got != 1) begin errors++; $display("FAIL clr_next_count got %0d want 1", got); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_signed();
    test_five();
    test_rst_midflight();
    test_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
